// File: rtl/seq_det_pkg.sv
// Shared definitions for the time-shared run detector: state codes and the
// default channel count.
package seq_det_pkg;

    localparam int N_CH_DEF = 4;

    typedef enum logic [3:0] {
        ST_A = 4'd0,
        ST_B = 4'd1,
        ST_C = 4'd2,
        ST_D = 4'd3,
        ST_E = 4'd4,
        ST_F = 4'd5,
        ST_G = 4'd6,
        ST_H = 4'd7,
        ST_I = 4'd8
    } state_e;

endpackage

// File: rtl/run_detect_step.sv
// One step of the run detector: context + serial bit -> next context and z.
// Purely combinational so a single copy can be shared across channels.
module run_detect_step
    import seq_det_pkg::*;
(
    input  logic [3:0] ctx_i,
    input  logic       w_i,
    output logic [3:0] nxt_o,
    output logic       z_o
);

    state_e cur;
    state_e nxt;

    always_comb begin
        // unused codes 9..15 restart from A
        cur = (ctx_i > 4'd8) ? ST_A : state_e'(ctx_i);
        if (!w_i) begin
            case (cur)
                ST_B:       nxt = ST_C;
                ST_C:       nxt = ST_D;
                ST_D, ST_E: nxt = ST_E;
                default:    nxt = ST_B;
            endcase
        end else begin
            case (cur)
                ST_F:       nxt = ST_G;
                ST_G:       nxt = ST_H;
                ST_H, ST_I: nxt = ST_I;
                default:    nxt = ST_F;
            endcase
        end
        nxt_o = nxt;
        z_o   = (nxt == ST_E) || (nxt == ST_I);
    end

endmodule

// File: rtl/seq_detect_arbiter.sv
// Round-robin arbiter feeding one shared run-detector step; holds the
// per-channel contexts, registered result and saturating hit counter.
module seq_detect_arbiter
    import seq_det_pkg::*;
#(
    parameter int N_CH = N_CH_DEF
) (
    input  logic                  clk,
    input  logic                  aclr,
    input  logic [N_CH-1:0]       req,
    input  logic [N_CH-1:0]       w,
    input  logic [N_CH-1:0]       clr_ch,
    output logic [N_CH-1:0]       gnt,
    output logic                  vld,
    output logic [$clog2(N_CH)-1:0] vld_ch,
    output logic                  z,
    output logic [3:0]            y,
    output logic [7:0]            hit_cnt
);

    localparam int IW = $clog2(N_CH);

    logic [N_CH-1:0][3:0] ctx_q;
    logic [IW-1:0]        ptr_q;
    logic                 vld_q;
    logic [IW-1:0]        vld_ch_q;
    logic                 z_q;
    logic [3:0]           y_q;
    logic [7:0]           hit_q;

    logic [N_CH-1:0]      elig;
    logic [N_CH-1:0]      gnt_d;
    logic [IW-1:0]        gidx;
    logic                 any_gnt;
    logic [3:0]           ctx_d;
    logic                 z_d;

    // search from ptr_q+1 wrapping; the first eligible channel wins
    always_comb begin
        int            c;
        logic [IW-1:0] cidx;
        elig    = req & ~clr_ch;
        gnt_d   = '0;
        gidx    = '0;
        any_gnt = 1'b0;
        c       = 0;
        cidx    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            c = int'(ptr_q) + i;
            if (c >= N_CH) c = c - N_CH;
            cidx = IW'(c);
            if (!any_gnt && elig[cidx]) begin
                any_gnt = 1'b1;
                gidx    = cidx;
            end
        end
        if (!aclr) any_gnt = 1'b0;
        if (any_gnt) gnt_d[gidx] = 1'b1;
    end

    run_detect_step u_step (
        .ctx_i (ctx_q[gidx]),
        .w_i   (w[gidx]),
        .nxt_o (ctx_d),
        .z_o   (z_d)
    );

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            for (int k = 0; k < N_CH; k++) ctx_q[k] <= ST_A;
            ptr_q    <= IW'(N_CH - 1);
            vld_q    <= 1'b0;
            vld_ch_q <= '0;
            z_q      <= 1'b0;
            y_q      <= '0;
            hit_q    <= '0;
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (clr_ch[k])     ctx_q[k] <= ST_A;
                else if (gnt_d[k]) ctx_q[k] <= ctx_d;
            end
            vld_q <= any_gnt;
            if (any_gnt) begin
                ptr_q    <= gidx;
                vld_ch_q <= gidx;
                y_q      <= ctx_d;
                z_q      <= z_d;
                if (z_d && hit_q != 8'hFF) hit_q <= hit_q + 8'd1;
            end
        end
    end

    assign gnt     = gnt_d;
    assign vld     = vld_q;
    assign vld_ch  = vld_ch_q;
    assign z       = z_q;
    assign y       = y_q;
    assign hit_cnt = hit_q;

endmodule

// File: tb/tb_seq_detect_arbiter.sv
// Directed plus random bench for seq_detect_arbiter; the reference tracks each
// channel as a run length of equal bits rather than as detector states.
module tb_seq_detect_arbiter;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 aclr = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N-1:0]         w = '0;
    logic [N-1:0]         clr_ch = '0;
    logic [N-1:0]         gnt;
    logic                 vld;
    logic [$clog2(N)-1:0] vld_ch;
    logic                 z;
    logic [3:0]           y;
    logic [7:0]           hit_cnt;

    seq_detect_arbiter #(.N_CH(N)) dut (
        .clk(clk), .aclr(aclr), .req(req), .w(w), .clr_ch(clr_ch),
        .gnt(gnt), .vld(vld), .vld_ch(vld_ch), .z(z), .y(y), .hit_cnt(hit_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference: run length of identical bits per channel (0 = no history)
    int mrun[N];
    bit mbit[N];
    int mptr, mhit, mvch, my;
    bit mvld, mz;

    function automatic int code(input int run, input bit b);
        int r;
        if (run == 0) return 0;
        r = (run > 4) ? 4 : run;
        return b ? 4 + r : r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin mrun[k] = 0; mbit[k] = 1'b0; end
        mptr = N - 1; mhit = 0; mvch = 0; my = 0; mvld = 1'b0; mz = 1'b0;
    endtask

    task automatic check_outs(input string tag);
        chk({tag, ".vld"}, 32'(vld), 32'(mvld));
        chk({tag, ".vld_ch"}, 32'(vld_ch), mvch);
        chk({tag, ".y"}, 32'(y), my);
        chk({tag, ".z"}, 32'(z), 32'(mz));
        chk({tag, ".hit"}, 32'(hit_cnt), mhit);
    endtask

    task automatic do_reset();
        req = '0; w = '0; clr_ch = '0;
        aclr = 1'b0;
        #1;
        model_reset();
        chk("rst.gnt", 32'(gnt), 0);
        check_outs("rst");
        @(negedge clk);
        aclr = 1'b1;
    endtask

    task automatic cycle(input logic [N-1:0] r, input logic [N-1:0] wv, input logic [N-1:0] cl);
        int g;
        bit b;
        g = -1;
        @(negedge clk);
        req = r; w = wv; clr_ch = cl;
        #1;
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (mptr + i) % N;
            if (g < 0 && r[c] && !cl[c]) g = c;
        end
        chk("gnt", 32'(gnt), (g < 0) ? 0 : (1 << g));
        @(posedge clk);
        for (int k = 0; k < N; k++) if (cl[k]) mrun[k] = 0;
        if (g >= 0) begin
            b = wv[g];
            if (mrun[g] > 0 && mbit[g] == b) mrun[g]++;
            else begin mrun[g] = 1; mbit[g] = b; end
            my = code(mrun[g], mbit[g]);
            mz = (mrun[g] >= 4);
            mvch = g; mptr = g; mvld = 1'b1;
            if (mz && mhit < 255) mhit++;
        end else begin
            mvld = 1'b0;
        end
        #1;
        check_outs("cyc");
    endtask

    initial begin
        do_reset();

        // channel 0, five zeros: y 1,2,3,4,4, two hits
        for (int i = 0; i < 5; i++) cycle(4'b0001, 4'b0000, 4'b0000);
        chk("r033.y", 32'(y), 4);
        chk("r033.hit", 32'(hit_cnt), 2);

        // all requesting: 0,1,2,3,0,1
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(4'b1111, 4'($urandom), 4'b0000);
            chk("r034.order", 32'(vld_ch), i % N);
        end

        // channel 2: three ones, clear while requesting, then one
        do_reset();
        for (int i = 0; i < 3; i++) cycle(4'b0100, 4'b0100, 4'b0000);
        cycle(4'b0100, 4'b0100, 4'b0100);
        chk("r035.noclrvld", 32'(vld), 0);
        cycle(4'b0100, 4'b0100, 4'b0000);
        chk("r035.y", 32'(y), 5);
        chk("r035.z", 32'(z), 0);

        // channel 1 up to H with channel 3 interleaved, then to I
        do_reset();
        cycle(4'b0010, 4'b0010, 4'b0000);
        cycle(4'b1000, 4'b0000, 4'b0000);
        cycle(4'b0010, 4'b0010, 4'b0000);
        cycle(4'b1000, 4'b0000, 4'b0000);
        cycle(4'b0010, 4'b0010, 4'b0000);
        cycle(4'b0010, 4'b0010, 4'b0000);
        chk("r036.y", 32'(y), 8);
        chk("r036.z", 32'(z), 1);
        cycle(4'b1000, 4'b0000, 4'b0000);
        chk("r036.ch3", 32'(y), 3);

        // random traffic
        for (int i = 0; i < 400; i++)
            cycle(4'($urandom), 4'($urandom),
                  ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000);

        // saturate hit counter
        do_reset();
        for (int i = 0; i < 303; i++) cycle(4'b0001, 4'b0001, 4'b0000);
        chk("r038.hit", 32'(hit_cnt), 255);

        // asynchronous reset in the middle of a burst
        cycle(4'b1111, 4'b0000, 4'b0000);
        @(negedge clk);
        req = 4'b1111;
        #2;
        aclr = 1'b0;
        #1;
        model_reset();
        chk("r037.gnt", 32'(gnt), 0);
        check_outs("r037");
        @(negedge clk);
        #1;
        chk("r037.gnt_held", 32'(gnt), 0);
        aclr = 1'b1;
        req = '0;
        cycle(4'b0001, 4'b0000, 4'b0000);
        chk("r037.y", 32'(y), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_detect_arbiter.md
SEQ_DETECT_ARBITER -- requirements
Module: seq_detect_arbiter

Interface
REQ-001 Parameter: N_CH, 4, number of requesting channels (2..8).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: aclr  input  1  reset, asynchronous, active-low.
REQ-004 Port: req  input  N_CH  per-channel request; one serial bit offered this cycle.
REQ-005 Port: w  input  N_CH  per-channel serial data bit, qualified by req.
REQ-006 Port: clr_ch  input  N_CH  per-channel synchronous context clear.
REQ-007 Port: gnt  output  N_CH  one-hot combinational grant; channel's bit consumed at this clock edge.
REQ-008 Port: vld  output  1  registered result valid, one cycle per grant.
REQ-009 Port: vld_ch  output  $clog2(N_CH)  index of the channel the result belongs to.
REQ-010 Port: z  output  1  run detected for vld_ch: four or more consecutive equal bits.
REQ-011 Port: y  output  4  updated context state of vld_ch.
REQ-012 Port: hit_cnt  output  8  saturating count of results with z=1.

Function
REQ-013 The block SHALL time-share one run-detector engine across N_CH channels, with a 4-bit context register per channel.
REQ-014 State codes: A=0, B=1, C=2, D=3, E=4, F=5, G=6, H=7, I=8.
REQ-015 Next state, w=0: A,B,C,F,G,H,I->B except B->C, C->D, D->E, E->E; i.e. A/F/G/H/I->B.
REQ-016 Next state, w=1: A,B,C,D,E->F; F->G, G->H, H->I, I->I.
REQ-017 z SHALL be 1 if the updated state is E or I, else 0.
REQ-018 Context codes 9..15 SHALL be treated as A by the engine.
REQ-019 Arbitration SHALL be round-robin: search starts at (last granted + 1) mod N_CH; at most one gnt bit per cycle.
REQ-020 gnt SHALL be zero when no eligible req is present; the last-granted pointer then holds.
REQ-021 A channel with clr_ch=1 SHALL be ineligible that cycle; its context is set to A at the edge.
REQ-022 At the edge ending a cycle with gnt[k]=1: context[k] updates, vld=1, vld_ch=k, y=new state, z per REQ-017, pointer=k.
REQ-023 Latency: result visible exactly one cycle after the granting cycle; back-to-back grants give back-to-back vld.
REQ-024 With no grant, vld SHALL be 0 the next cycle; y, z and vld_ch hold their last values.
REQ-025 hit_cnt SHALL increment on each vld with z=1 and saturate at 255.
REQ-026 Non-granted channels' contexts SHALL be unchanged except by clr_ch.

Reset
REQ-027 aclr low SHALL immediately set all contexts to A, pointer to N_CH-1 (channel 0 first), vld=0, vld_ch=0, z=0, y=0, hit_cnt=0.
REQ-028 Reset mid-stream SHALL discard all run history; the first post-reset result for a channel starts from A.
REQ-029 gnt SHALL be 0 while aclr is low.

Structure
REQ-030 State codes A..I and the default N_CH SHALL live in shared package seq_det_pkg.
REQ-031 The engine (context, w -> next state, z) SHALL be a combinational sub-module run_detect_step, instantiated once.
REQ-032 Arbiter, context array, output registers and hit counter SHALL reside in seq_detect_arbiter.

Verification
REQ-033 Channel 0 only, w=0 for 5 grants -> y=1,2,3,4,4; z=0,0,0,1,1; hit_cnt=2.
REQ-034 All req=1 for 6 cycles after reset -> gnt order 0,1,2,3,0,1; vld_ch matches one cycle later.
REQ-035 Channel 2 w=1,1,1 then clr_ch[2] with req[2]=1, then w=1 -> no grant in clr cycle; next y=5 (F), z=0.
REQ-036 Channel 1 at H, channel 3 interleaved, then channel 1 w=1 -> y=8, z=1; channel 3 context unaffected.
REQ-037 aclr asserted mid-burst -> gnt, vld, hit_cnt immediately 0; after release channel 0 w=0 gives y=1.
REQ-038 300 z=1 results -> hit_cnt stops at 255.
